mips32_prog_loader: RTL and testbench
=====================================

# mips32_prog_loader

Program loader that sits directly upstream of the MIPS32 core. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into the core's instruction memory starting at address 0. It holds the core halted while loading, then issues a one-cycle start pulse (PC=0, HALTED=0, TAKEN_BRANCH=0). It watches the core's halt flag and reports completion. It replaces hierarchical memory pokes for system-level runs.

## Interface
- `ADDR_W`, 10, instruction-memory word-address width
- `MAX_WORDS`, 1024, program capacity in words; must be ≤ 2**ADDR_W
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  loader can accept a beat
- `in_data`  in  32  instruction word
- `in_last`  in  1  marks final beat of program
- `mem_we`  out  1  instruction-memory write strobe
- `mem_addr`  out  ADDR_W  write word address
- `mem_wdata`  out  32  write data
- `core_hold`  out  1  keeps core halted
- `core_start`  out  1  one-cycle pulse: core loads PC=0, clears HALTED and TAKEN_BRANCH
- `core_halted`  in  1  core HALTED flag
- `reload`  in  1  return from DONE/ERROR to IDLE
- `word_count`  out  ADDR_W+1  words written this load
- `done`  out  1  program ran to HLT
- `err`  out  1  overflow or checksum failure

## Operation
- States: IDLE, LOAD, START, RUN, DONE, ERROR. All outputs are registered.
- Reset values: state=IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, core_start=0, word_count=0, done=0, err=0.
- A beat is accepted when in_valid and in_ready are both high. in_ready is high only in IDLE and LOAD.
- IDLE → LOAD on the first accepted beat. Each accepted program beat writes in_data to address word_count, then increments word_count.
- Accepted beat with in_last=1 → START. START lasts one cycle, with core_start=1 and core_hold=0. Then → RUN.
- RUN: core_hold=0. core_halted=1 → DONE. DONE: done=1, sticky.
- Overflow: accepted beat with in_last=0 when word_count==MAX_WORDS-1 → ERROR after that word is written. ERROR: err=1, in_ready=0, core_hold=1.
- reload=1 in DONE or ERROR → IDLE on the next edge. This clears word_count, done and err and sets core_hold=1. reload is ignored in all other states.
- in_valid=0 mid-load: stay in LOAD indefinitely; no timeout.
- rst mid-load: immediate return to reset values. Memory contents are undefined.

## Timing
- Beat accepted at edge N: mem_we, mem_addr and mem_wdata are high/valid for the cycle after edge N, so the write commits at edge N+1.
- Last beat accepted at edge N: state=START after edge N+1. core_start is high for exactly one cycle, between edges N+1 and N+2, after the last write has committed.
- core_hold falls in the same cycle that core_start rises.
- core_halted is sampled from the START cycle onward.
- in_ready falls in the cycle after the accepting edge for the last beat or an overflow beat. A beat offered in that cycle is not accepted.
- Throughput: one word per cycle.

## Configuration
- `MIPS32_LOADER_CHECKSUM_EN` defined: the in_last beat carries an XOR checksum of all prior words and is not written to memory.
  - Match → START.
  - Mismatch → ERROR with err=1, and core_start is never pulsed.
  - A lone in_last beat with no program words is compared against 0.
- Undefined: the in_last beat is an ordinary program word. No checksum logic is present.

## Structure
- Shared package `mips32_pkg` holds:
  - the loader state enum;
  - the HLT opcode constant 6'h3f;
  - default ADDR_W and MAX_WORDS.
- Sub-module `mips32_loader_csum` (running XOR accumulator with clear, enable and compare) is present only under the macro.

## Test plan
- Stream the 9-word program 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 (last on fc000000) → 9 writes at addr 0–8, word_count=9, one core_start pulse two edges after the last beat, done=1 after core_halted. A real core ends with R5=55.
- Same stream with in_valid deasserted for 3 cycles after beats 2 and 6 → identical memory image, no extra writes, core_start delayed by 6 cycles.
- MAX_WORDS=4, 5 beats with no in_last → 4 writes, err=1, in_ready=0, core_start never asserted. Then reload → IDLE with err=0.
- rst pulsed after the 4th beat → all outputs at reset values within the same cycle. A full reload then succeeds.
- With the macro: words 1, 2, 4 and checksum 7 → 3 writes, start pulse. With checksum 6 → err=1, no start.
- DONE, then reload, then a second 2-word program → writes at addr 0–1, word_count=2, done re-asserts only after the new core_halted.

Source files
------------

// File: rtl/mips32_pkg.sv
// ---------------------------------------------------------------------------
// mips32_pkg
// Shared definitions for the MIPS32 program loader: the loader state
// encoding, the HLT opcode and the default memory geometry.
// Ports: none (package).
// ---------------------------------------------------------------------------
package mips32_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

    // Primary opcode of the core's HLT instruction
    localparam logic [5:0] HLT_OPCODE = 6'h3f;

    // Default instruction-memory geometry
    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_MAX_WORDS = 1024;

endpackage

// File: rtl/mips32_loader_csum.sv
// ---------------------------------------------------------------------------
// mips32_loader_csum
// Running XOR accumulator over the program words of one load. Used only
// when MIPS32_LOADER_CHECKSUM_EN is defined.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_clr     : synchronous clear of the accumulator
//   i_en      : fold i_data into the accumulator
//   i_data    : program word
//   i_cmp     : value to compare against the current accumulator
//   o_match   : accumulator equals i_cmp
// ---------------------------------------------------------------------------
module mips32_loader_csum (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [31:0] i_data,
    input  logic [31:0] i_cmp,
    output logic        o_match
);

    logic [31:0] r_acc;

    // XOR accumulator, cleared at the start of every load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= 32'h0000_0000;
        end else if (i_clr) begin
            r_acc <= 32'h0000_0000;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_data;
        end else begin
            r_acc <= r_acc;
        end
    end

    // Compare is against the accumulator before the checksum beat itself
    assign o_match = (r_acc == i_cmp);

endmodule

// File: rtl/mips32_prog_loader.sv
// ---------------------------------------------------------------------------
// mips32_prog_loader
// Streams 32-bit instruction words into the MIPS32 core's instruction
// memory from address 0, holds the core while loading, pulses core_start
// once the last word has committed, then watches core_halted for completion.
// Optional feature macro: MIPS32_LOADER_CHECKSUM_EN -- the in_last beat is
// an XOR checksum of the prior words and is not written.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_last : program word stream
//   mem_we/mem_addr/mem_wdata : instruction-memory write port
//   core_hold, core_start     : core control (hold, one-cycle start)
//   core_halted               : core HALTED flag
//   reload                    : return from DONE/ERROR to IDLE
//   word_count, done, err     : status
// ---------------------------------------------------------------------------
module mips32_prog_loader
    import mips32_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              core_start,
    input  logic              core_halted,
    input  logic              reload,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] LP_LAST_IDX = (ADDR_W+1)'(MAX_WORDS - 1);
    localparam logic [ADDR_W:0] LP_WC_ONE   = (ADDR_W+1)'(1);

    loader_state_t     r_state, w_state_n;
    logic              r_in_ready, w_in_ready_n;
    logic              r_mem_we, w_mem_we_n;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_n;
    logic [31:0]       r_mem_wdata, w_mem_wdata_n;
    logic              r_core_hold, w_core_hold_n;
    logic              r_core_start, w_core_start_n;
    logic [ADDR_W:0]   r_word_count, w_word_count_n;
    logic              r_done, w_done_n;
    logic              r_err, w_err_n;
    // A final or overflowing beat was accepted; resolve it once its write commits
    logic              r_pend, w_pend_n;
    logic              r_pend_err, w_pend_err_n;

    logic              w_accept;
    logic              w_csum_beat;
    logic              w_csum_match;

    assign w_accept = in_valid & r_in_ready;

`ifdef MIPS32_LOADER_CHECKSUM_EN
    logic w_csum_clr;
    logic w_csum_en;

    mips32_loader_csum u_csum (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_csum_clr),
        .i_en    (w_csum_en),
        .i_data  (in_data),
        .i_cmp   (in_data),
        .o_match (w_csum_match)
    );

    assign w_csum_beat = in_last;
`else
    assign w_csum_beat  = 1'b0;
    assign w_csum_match = 1'b1;
`endif

    // Next-state and next-output computation
    always_comb begin
        w_state_n      = r_state;
        w_in_ready_n   = r_in_ready;
        w_mem_we_n     = 1'b0;
        w_mem_addr_n   = r_mem_addr;
        w_mem_wdata_n  = r_mem_wdata;
        w_core_hold_n  = r_core_hold;
        w_core_start_n = 1'b0;
        w_word_count_n = r_word_count;
        w_done_n       = r_done;
        w_err_n        = r_err;
        w_pend_n       = r_pend;
        w_pend_err_n   = r_pend_err;
`ifdef MIPS32_LOADER_CHECKSUM_EN
        w_csum_clr     = 1'b0;
        w_csum_en      = 1'b0;
`endif

        case (r_state)
            ST_IDLE, ST_LOAD: begin
                if (r_pend) begin
                    // Last write is committing on this edge
                    w_pend_n = 1'b0;
                    if (r_pend_err) begin
                        w_state_n     = ST_ERROR;
                        w_err_n       = 1'b1;
                        w_core_hold_n = 1'b1;
                    end else begin
                        w_state_n      = ST_START;
                        w_core_start_n = 1'b1;
                        w_core_hold_n  = 1'b0;
                    end
                end else if (w_accept) begin
                    w_state_n = ST_LOAD;
                    if (w_csum_beat) begin
                        // Checksum beat: compared, never written
                        w_pend_n     = 1'b1;
                        w_pend_err_n = ~w_csum_match;
                        w_in_ready_n = 1'b0;
                    end else begin
                        w_mem_we_n     = 1'b1;
                        w_mem_addr_n   = r_word_count[ADDR_W-1:0];
                        w_mem_wdata_n  = in_data;
                        w_word_count_n = r_word_count + LP_WC_ONE;
`ifdef MIPS32_LOADER_CHECKSUM_EN
                        w_csum_en      = 1'b1;
`endif
                        if (in_last) begin
                            w_pend_n     = 1'b1;
                            w_pend_err_n = 1'b0;
                            w_in_ready_n = 1'b0;
                        end else if (r_word_count == LP_LAST_IDX) begin
                            // Capacity reached without in_last
                            w_pend_n     = 1'b1;
                            w_pend_err_n = 1'b1;
                            w_in_ready_n = 1'b0;
                        end else begin
                            w_pend_n = 1'b0;
                        end
                    end
                end else begin
                    w_state_n = r_state;
                end
            end
            ST_START: begin
                w_core_hold_n = 1'b0;
                if (core_halted) begin
                    w_state_n = ST_DONE;
                    w_done_n  = 1'b1;
                end else begin
                    w_state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                w_core_hold_n = 1'b0;
                if (core_halted) begin
                    w_state_n = ST_DONE;
                    w_done_n  = 1'b1;
                end else begin
                    w_state_n = ST_RUN;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (reload) begin
                    w_state_n      = ST_IDLE;
                    w_word_count_n = '0;
                    w_done_n       = 1'b0;
                    w_err_n        = 1'b0;
                    w_core_hold_n  = 1'b1;
                    w_in_ready_n   = 1'b1;
`ifdef MIPS32_LOADER_CHECKSUM_EN
                    w_csum_clr     = 1'b1;
`endif
                end else begin
                    w_state_n = r_state;
                end
            end
            default: begin
                w_state_n      = ST_IDLE;
                w_in_ready_n   = 1'b1;
                w_core_hold_n  = 1'b1;
                w_word_count_n = '0;
                w_done_n       = 1'b0;
                w_err_n        = 1'b0;
                w_pend_n       = 1'b0;
                w_pend_err_n   = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_in_ready   <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'h0000_0000;
            r_core_hold  <= 1'b1;
            r_core_start <= 1'b0;
            r_word_count <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_err   <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_in_ready   <= w_in_ready_n;
            r_mem_we     <= w_mem_we_n;
            r_mem_addr   <= w_mem_addr_n;
            r_mem_wdata  <= w_mem_wdata_n;
            r_core_hold  <= w_core_hold_n;
            r_core_start <= w_core_start_n;
            r_word_count <= w_word_count_n;
            r_done       <= w_done_n;
            r_err        <= w_err_n;
            r_pend       <= w_pend_n;
            r_pend_err   <= w_pend_err_n;
        end
    end

    assign in_ready   = r_in_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign core_hold  = r_core_hold;
    assign core_start = r_core_start;
    assign word_count = r_word_count;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_mips32_prog_loader
// Self-checking bench for mips32_prog_loader. A full-size instance and a
// 4-word instance share the input stream; each scenario task compares the
// captured writes, start pulse timing and status against expectations
// derived from the program list.
// ---------------------------------------------------------------------------
module tb_mips32_prog_loader;

    localparam int AW  = 10;
    localparam int MW  = 1024;
    localparam int SMW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data = 32'h0;
    logic          in_last = 1'b0;
    logic          core_halted = 1'b0;
    logic          reload = 1'b0;

    logic          in_ready, mem_we, core_hold, core_start, done, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   word_count;

    logic          s_in_ready, s_mem_we, s_core_hold, s_core_start, s_done, s_err;
    logic [AW-1:0] s_mem_addr;
    logic [31:0]   s_mem_wdata;
    logic [AW:0]   s_word_count;

    mips32_prog_loader #(.ADDR_W(AW), .MAX_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_hold(core_hold),
        .core_start(core_start), .core_halted(core_halted), .reload(reload),
        .word_count(word_count), .done(done), .err(err)
    );

    mips32_prog_loader #(.ADDR_W(AW), .MAX_WORDS(SMW)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .mem_we(s_mem_we),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .core_hold(s_core_hold),
        .core_start(s_core_start), .core_halted(core_halted), .reload(reload),
        .word_count(s_word_count), .done(s_done), .err(s_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Edge counter: at a falling edge, cyc is the number of the last rising edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed write and start history
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          start_cyc_q[$];
    int          start_hold_bad = 0;
    int          s_wr_cnt = 0;
    int          s_start_cnt = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(mem_wdata);
        end
        if (core_start) begin
            start_cyc_q.push_back(cyc);
            if (core_hold) start_hold_bad++;
        end
        if (s_mem_we) s_wr_cnt++;
        if (s_core_start) s_start_cnt++;
    end

    // Stimulus state
    logic [31:0] word_q[$];
    logic [31:0] beat_q[$];
    int          gap_q[$];
    int          acc_q[$];
    bit          send_last = 1'b1;
    bit          use_small = 1'b0;

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; reload = 1'b0; core_halted = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Beat list from program words; with the checksum feature a final XOR beat is appended
    task automatic make_beats();
        logic [31:0] x;
        x = 32'h0;
        beat_q.delete();
        foreach (word_q[i]) begin
            beat_q.push_back(word_q[i]);
            x = x ^ word_q[i];
        end
`ifdef MIPS32_LOADER_CHECKSUM_EN
        beat_q.push_back(x);
`endif
    endtask

    // Offer beat_q one beat per cycle (plus gap_q idle cycles), logging accept edges
    task automatic stream_beats();
        int waited;
        acc_q.delete();
        for (int i = 0; i < beat_q.size(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = beat_q[i];
            in_last  = send_last && (i == beat_q.size() - 1);
            waited = 0;
            while (!(use_small ? s_in_ready : in_ready) && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            if (!(use_small ? s_in_ready : in_ready)) begin
                n_checks++; n_fail++;
                $display("FAIL stream_ready: beat %0d never accepted, in_ready=0 required=1", i);
                break;
            end
            acc_q.push_back(cyc + 1);
            if (i < gap_q.size() && gap_q[i] > 0) begin
                @(negedge clk);
                in_valid = 1'b0; in_last = 1'b0;
                repeat (gap_q[i] - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_start(input int base, input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (start_cyc_q.size() > base) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready, mem_we, core_hold, core_start, done, err} !== 6'b101000) begin
            n_fail++; $display("FAIL reset_flags: got %b required 101000",
                {in_ready, mem_we, core_hold, core_start, done, err});
        end
        n_checks++;
        if (mem_addr !== '0 || mem_wdata !== 32'h0 || word_count !== '0) begin
            n_fail++; $display("FAIL reset_values: addr=%0d wdata=%h wc=%0d required 0", mem_addr, mem_wdata, word_count);
        end
        n_checks++;
        if (s_in_ready !== 1'b1 || s_core_hold !== 1'b1 || s_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_small: ready=%b hold=%b err=%b required 1 1 0", s_in_ready, s_core_hold, s_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_program();
        int bw, bs;
        bit seen;
        do_reset();
        word_q = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                   32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        make_beats(); gap_q.delete(); send_last = 1'b1; use_small = 1'b0;
        bw = wr_addr_q.size(); bs = start_cyc_q.size();
        stream_beats();
        // A beat offered in the cycle after the last accept must be refused
        in_valid = 1'b1; in_data = 32'hdeadbeef; in_last = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL prog_ready_after_last: in_ready=%b required 0", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        wait_start(bs, 20, seen);
        n_checks++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL prog_start_seen: got %b required 1", seen); end
        n_checks++;
        if (wr_addr_q.size() - bw !== word_q.size()) begin
            n_fail++; $display("FAIL prog_write_count: got %0d required %0d", wr_addr_q.size() - bw, word_q.size());
        end
        for (int i = 0; i < word_q.size() && bw + i < wr_addr_q.size(); i++) begin
            n_checks++;
            if (wr_addr_q[bw+i] !== i || wr_data_q[bw+i] !== word_q[i]) begin
                n_fail++; $display("FAIL prog_write: addr=%0d data=%h required addr=%0d data=%h",
                    wr_addr_q[bw+i], wr_data_q[bw+i], i, word_q[i]);
            end
        end
        if (seen) begin
            n_checks++;
            if (start_cyc_q[bs] !== acc_q[0] + beat_q.size()) begin
                n_fail++; $display("FAIL prog_start_time: edge %0d required %0d", start_cyc_q[bs], acc_q[0] + beat_q.size());
            end
        end
        n_checks++;
        if (int'(word_count) !== word_q.size()) begin
            n_fail++; $display("FAIL prog_word_count: got %0d required %0d", word_count, word_q.size());
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || core_hold !== 1'b0) begin
            n_fail++; $display("FAIL prog_run_state: done=%b hold=%b required 0 0", done, core_hold);
        end
        core_halted = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL prog_done: done=%b err=%b required 1 0", done, err);
        end
        n_checks++;
        if (start_cyc_q.size() - bs !== 1 || start_hold_bad !== 0) begin
            n_fail++; $display("FAIL prog_start_pulse: pulses=%0d hold_bad=%0d required 1 0", start_cyc_q.size() - bs, start_hold_bad);
        end
    endtask

    task automatic test_gaps();
        int bw, bs;
        bit seen;
        do_reset();
        word_q = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                   32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        make_beats();
        gap_q = '{0, 3, 0, 0, 0, 3, 0, 0, 0};
        bw = wr_addr_q.size(); bs = start_cyc_q.size();
        stream_beats();
        wait_start(bs, 30, seen);
        n_checks++;
        if (wr_addr_q.size() - bw !== word_q.size()) begin
            n_fail++; $display("FAIL gaps_write_count: got %0d required %0d", wr_addr_q.size() - bw, word_q.size());
        end
        for (int i = 0; i < word_q.size() && bw + i < wr_addr_q.size(); i++) begin
            n_checks++;
            if (wr_addr_q[bw+i] !== i || wr_data_q[bw+i] !== word_q[i]) begin
                n_fail++; $display("FAIL gaps_write: addr=%0d data=%h required addr=%0d data=%h",
                    wr_addr_q[bw+i], wr_data_q[bw+i], i, word_q[i]);
            end
        end
        n_checks++;
        if (seen !== 1'b1 || start_cyc_q[start_cyc_q.size()-1] !== acc_q[0] + beat_q.size() + 6) begin
            n_fail++; $display("FAIL gaps_start_time: seen=%b edge %0d required %0d", seen,
                start_cyc_q[start_cyc_q.size()-1], acc_q[0] + beat_q.size() + 6);
        end
        gap_q.delete();
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 6; it++) begin
            int n, bw, bs, exp_start, hold_cycles;
            bit seen;
            n = $urandom_range(12, 1);
            word_q.delete(); gap_q.delete();
            for (int k = 0; k < n; k++) word_q.push_back($urandom());
            make_beats();
            for (int k = 0; k < beat_q.size(); k++) gap_q.push_back($urandom_range(2, 0));
            exp_start = 0;
            for (int k = 0; k < beat_q.size() - 1; k++) exp_start += gap_q[k];
            bw = wr_addr_q.size(); bs = start_cyc_q.size();
            stream_beats();
            exp_start += acc_q[0] + beat_q.size();
            wait_start(bs, 40, seen);
            n_checks++;
            if (seen !== 1'b1 || start_cyc_q[start_cyc_q.size()-1] !== exp_start) begin
                n_fail++; $display("FAIL rand_start_time: seen=%b edge %0d required %0d", seen,
                    start_cyc_q[start_cyc_q.size()-1], exp_start);
            end
            n_checks++;
            if (wr_addr_q.size() - bw !== n || int'(word_count) !== n) begin
                n_fail++; $display("FAIL rand_count: writes=%0d wc=%0d required %0d", wr_addr_q.size() - bw, word_count, n);
            end
            for (int i = 0; i < n && bw + i < wr_addr_q.size(); i++) begin
                n_checks++;
                if (wr_addr_q[bw+i] !== i || wr_data_q[bw+i] !== word_q[i]) begin
                    n_fail++; $display("FAIL rand_write: addr=%0d data=%h required addr=%0d data=%h",
                        wr_addr_q[bw+i], wr_data_q[bw+i], i, word_q[i]);
                end
            end
            hold_cycles = $urandom_range(3, 1);
            repeat (hold_cycles) @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL rand_done_early: done=%b required 0", done); end
            core_halted = 1'b1;
            @(negedge clk);
            n_checks++;
            if (done !== 1'b1) begin n_fail++; $display("FAIL rand_done: done=%b required 1", done); end
            reload = 1'b1; core_halted = 1'b0;
            @(negedge clk);
            reload = 1'b0;
            n_checks++;
            if (in_ready !== 1'b1 || word_count !== '0 || done !== 1'b0 || core_hold !== 1'b1) begin
                n_fail++; $display("FAIL rand_reload: ready=%b wc=%0d done=%b hold=%b required 1 0 0 1",
                    in_ready, word_count, done, core_hold);
            end
        end
        gap_q.delete();
    endtask

    task automatic test_overflow();
        int bw, bs;
        do_reset();
        use_small = 1'b1; send_last = 1'b0;
        beat_q.delete();
        for (int k = 0; k < 4; k++) beat_q.push_back($urandom());
        bw = s_wr_cnt; bs = s_start_cnt;
        stream_beats();
        // Fifth beat with no in_last is offered and must be refused
        in_valid = 1'b1; in_data = 32'h0bad0bad; in_last = 1'b0;
        n_checks++;
        if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_fall: in_ready=%b required 0", s_in_ready); end
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_wr_cnt - bw !== 4 || int'(s_word_count) !== 4) begin
            n_fail++; $display("FAIL ovf_writes: writes=%0d wc=%0d required 4 4", s_wr_cnt - bw, s_word_count);
        end
        n_checks++;
        if (s_err !== 1'b1 || s_in_ready !== 1'b0 || s_core_hold !== 1'b1 || s_done !== 1'b0) begin
            n_fail++; $display("FAIL ovf_state: err=%b ready=%b hold=%b done=%b required 1 0 1 0",
                s_err, s_in_ready, s_core_hold, s_done);
        end
        n_checks++;
        if (s_start_cnt !== bs) begin n_fail++; $display("FAIL ovf_no_start: pulses=%0d required 0", s_start_cnt - bs); end
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        n_checks++;
        if (s_err !== 1'b0 || s_in_ready !== 1'b1 || s_word_count !== '0 || s_core_hold !== 1'b1) begin
            n_fail++; $display("FAIL ovf_reload: err=%b ready=%b wc=%0d hold=%b required 0 1 0 1",
                s_err, s_in_ready, s_word_count, s_core_hold);
        end
        use_small = 1'b0; send_last = 1'b1;
    endtask

    task automatic test_reset_midload();
        int bw, bs;
        bit seen;
        do_reset();
        word_q = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                   32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        make_beats();
        while (beat_q.size() > 4) void'(beat_q.pop_back());
        send_last = 1'b0;
        stream_beats();
        n_checks++;
        if (mem_we !== 1'b1 || int'(word_count) !== 4) begin
            n_fail++; $display("FAIL mid_before_rst: we=%b wc=%0d required 1 4", mem_we, word_count);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, mem_we, core_hold, core_start, done, err} !== 6'b101000 ||
            mem_addr !== '0 || mem_wdata !== 32'h0 || word_count !== '0) begin
            n_fail++; $display("FAIL mid_async_reset: flags=%b addr=%0d wdata=%h wc=%0d required 101000 0 0 0",
                {in_ready, mem_we, core_hold, core_start, done, err}, mem_addr, mem_wdata, word_count);
        end
        @(negedge clk);
        rst = 1'b0;
        send_last = 1'b1;
        make_beats();
        bw = wr_addr_q.size(); bs = start_cyc_q.size();
        stream_beats();
        wait_start(bs, 20, seen);
        n_checks++;
        if (seen !== 1'b1 || wr_addr_q.size() - bw !== word_q.size() || int'(word_count) !== word_q.size()) begin
            n_fail++; $display("FAIL mid_full_reload: seen=%b writes=%0d wc=%0d required 1 %0d %0d",
                seen, wr_addr_q.size() - bw, word_count, word_q.size(), word_q.size());
        end
    endtask

    task automatic test_reload_second();
        int bw, bs;
        bit seen;
        do_reset();
        word_q = '{32'h12345678, 32'hfc000000, 32'h0000abcd};
        make_beats();
        bs = start_cyc_q.size();
        stream_beats();
        wait_start(bs, 20, seen);
        core_halted = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL second_first_done: done=%b required 1", done); end
        reload = 1'b1; core_halted = 1'b0;
        @(negedge clk);
        reload = 1'b0;
        word_q = '{32'hcafef00d, 32'hfc000000};
        make_beats();
        bw = wr_addr_q.size(); bs = start_cyc_q.size();
        stream_beats();
        wait_start(bs, 20, seen);
        n_checks++;
        if (seen !== 1'b1 || wr_addr_q.size() - bw !== 2 || int'(word_count) !== 2) begin
            n_fail++; $display("FAIL second_load: seen=%b writes=%0d wc=%0d required 1 2 2", seen, wr_addr_q.size() - bw, word_count);
        end
        for (int i = 0; i < 2 && bw + i < wr_addr_q.size(); i++) begin
            n_checks++;
            if (wr_addr_q[bw+i] !== i || wr_data_q[bw+i] !== word_q[i]) begin
                n_fail++; $display("FAIL second_write: addr=%0d data=%h required addr=%0d data=%h",
                    wr_addr_q[bw+i], wr_data_q[bw+i], i, word_q[i]);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL second_done_early: done=%b required 0", done); end
        core_halted = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL second_done: done=%b required 1", done); end
        core_halted = 1'b0;
    endtask

`ifdef MIPS32_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int bw, bs;
        bit seen;
        logic [31:0] csums[3];
        csums[0] = 32'd7; csums[1] = 32'd6; csums[2] = 32'd0;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            beat_q.delete();
            if (t < 2) begin
                beat_q.push_back(32'd1); beat_q.push_back(32'd2); beat_q.push_back(32'd4);
            end
            beat_q.push_back(csums[t]);
            bw = wr_addr_q.size(); bs = start_cyc_q.size();
            stream_beats();
            wait_start(bs, 10, seen);
            n_checks++;
            if (wr_addr_q.size() - bw !== beat_q.size() - 1) begin
                n_fail++; $display("FAIL csum_writes[%0d]: got %0d required %0d", t, wr_addr_q.size() - bw, beat_q.size() - 1);
            end
            n_checks++;
            if (seen !== (t != 1) || err !== (t == 1)) begin
                n_fail++; $display("FAIL csum_result[%0d]: start=%b err=%b required start=%b err=%b",
                    t, seen, err, (t != 1), (t == 1));
            end
        end
    endtask
`else
    task automatic test_single_word();
        int bw, bs;
        bit seen;
        do_reset();
        word_q = '{32'hfc000000};
        make_beats();
        bw = wr_addr_q.size(); bs = start_cyc_q.size();
        stream_beats();
        wait_start(bs, 10, seen);
        n_checks++;
        if (seen !== 1'b1 || wr_addr_q.size() - bw !== 1 || int'(word_count) !== 1) begin
            n_fail++; $display("FAIL single_word: seen=%b writes=%0d wc=%0d required 1 1 1", seen, wr_addr_q.size() - bw, word_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_program();
        test_gaps();
        test_random();
        test_overflow();
        test_reset_midload();
        test_reload_second();
`ifdef MIPS32_LOADER_CHECKSUM_EN
        test_checksum();
`else
        test_single_word();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
